// File: rtl/vga_pkg.sv
// Shared timing constants, phase/state enums and phase decode helpers for the
// 640x480@60 VGA raster generator.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef enum logic [1:0] {HP_ACT, HP_FP, HP_SYNC, HP_BP} h_phase_e;
    typedef enum logic [1:0] {VP_ACT, VP_FP, VP_SYNC, VP_BP} v_phase_e;
    typedef enum logic {IDLE, RUN} run_state_e;

    // Phase boundaries compared as unsigned 10-bit values, matching the counters.
    function automatic h_phase_e h_phase_of(logic [9:0] h, int act, int fp, int sync);
        if (h < 10'(act))                 return HP_ACT;
        else if (h < 10'(act + fp))       return HP_FP;
        else if (h < 10'(act + fp + sync)) return HP_SYNC;
        else                              return HP_BP;
    endfunction

    function automatic v_phase_e v_phase_of(logic [9:0] v, int act, int fp, int sync);
        if (v < 10'(act))                 return VP_ACT;
        else if (v < 10'(act + fp))       return VP_FP;
        else if (v < 10'(act + fp + sync)) return VP_SYNC;
        else                              return VP_BP;
    endfunction

endpackage

// File: rtl/vga_if.sv
// Raster timing bundle between the timing generator (master) and the
// frame-buffer readout / connector side (slave).
interface vga_if;
    logic       Done640;
    logic [9:0] H_Count_Value;
    logic [9:0] V_Count_Value;
    logic       hsync;
    logic       vsync;
    logic       video_on;
    logic       pix_en;
    logic       frame_start;

    modport master (
        input  Done640,
        output H_Count_Value, V_Count_Value, hsync, vsync, video_on, pix_en, frame_start
    );

    modport slave (
        output Done640,
        input  H_Count_Value, V_Count_Value, hsync, vsync, video_on, pix_en, frame_start
    );
endinterface

// File: rtl/pix_clk_en.sv
// Pixel-rate strobe: one-clock pulse every CLK_DIV clocks while enabled.
// Holding en low keeps the divider at zero, so enabling restarts the phase.
module pix_clk_en #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic pix_en
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_q, div_d;

    always_comb begin
        div_d = div_q;
        if (!en || div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign pix_en = en && (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: parks in blanking until Done640, then free-runs
// H/V counters with syncs and flags registered alongside the counts.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE_P = H_ACTIVE,
    parameter int H_FP_P     = H_FP,
    parameter int H_SYNC_P   = H_SYNC,
    parameter int H_BP_P     = H_BP,
    parameter int V_ACTIVE_P = V_ACTIVE,
    parameter int V_FP_P     = V_FP,
    parameter int V_SYNC_P   = V_SYNC,
    parameter int V_BP_P     = V_BP
) (
    input  logic clk,
    input  logic rst,
    vga_if.master bus
);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P - 1);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P - 1);

    run_state_e state_q, state_d;
    logic [9:0] h_q, h_d, v_q, v_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d;
    logic       video_on_q, video_on_d, frame_start_q, frame_start_d;
    logic       run_en, pix_en;
    h_phase_e   h_phase_d;
    v_phase_e   v_phase_d;

    assign run_en = (state_q == RUN);

    pix_clk_en #(.CLK_DIV(CLK_DIV)) u_pix_clk_en (
        .clk    (clk),
        .rst    (rst),
        .en     (run_en),
        .pix_en (pix_en)
    );

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;

        if (state_q == IDLE && bus.Done640) begin
            state_d = RUN;
        end

        if (pix_en) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end

        // Flags decode the next counts so they land in the same clock as the counts.
        h_phase_d     = h_phase_of(h_d, H_ACTIVE_P, H_FP_P, H_SYNC_P);
        v_phase_d     = v_phase_of(v_d, V_ACTIVE_P, V_FP_P, V_SYNC_P);
        hsync_d       = (h_phase_d != HP_SYNC);
        vsync_d       = (v_phase_d != VP_SYNC);
        video_on_d    = (h_phase_d == HP_ACT) && (v_phase_d == VP_ACT);
        frame_start_d = pix_en && (h_d == 10'd0) && (v_d == 10'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            h_q           <= H_LAST;
            v_q           <= V_LAST;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.H_Count_Value = h_q;
    assign bus.V_Count_Value = v_q;
    assign bus.hsync         = hsync_q;
    assign bus.vsync         = vsync_q;
    assign bus.video_on      = video_on_q;
    assign bus.pix_en        = pix_en;
    assign bus.frame_start   = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen: a full-size 640x480 instance and a tiny
// timing instance (so whole frames fit in the run) checked against a time-based model.
module tb_vga_timing_gen;
    import vga_pkg::*;

    localparam int S_CD = 3;
    localparam int S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VA = 6, S_VF = 1, S_VS = 2, S_VB = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done = 1'b0;
    always #5 clk = ~clk;

    vga_if bus_f ();
    vga_if bus_s ();
    assign bus_f.Done640 = done;
    assign bus_s.Done640 = done;

    vga_timing_gen #(.CLK_DIV(2)) dut_full (
        .clk (clk),
        .rst (rst),
        .bus (bus_f)
    );

    vga_timing_gen #(
        .CLK_DIV(S_CD),
        .H_ACTIVE_P(S_HA), .H_FP_P(S_HF), .H_SYNC_P(S_HS), .H_BP_P(S_HB),
        .V_ACTIVE_P(S_VA), .V_FP_P(S_VF), .V_SYNC_P(S_VS), .V_BP_P(S_VB)
    ) dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       von;
        logic       pe;
        logic       fs;
    } exp_t;

    int errors = 0;
    int checks = 0;
    bit running = 1'b0;
    int t = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0d) at %0t", tag, obs, exp, t, $time);
        end
    endtask

    // Counts are a pure function of clocks elapsed since Done640 was taken:
    // the n-th pixel strobe (n>=1) shows pixel index n-1 of the raster.
    function automatic exp_t ref_model(bit run, int tt, int cd,
                                       int ha, int hf, int hs, int hb,
                                       int va, int vf, int vs, int vb);
        int ht, vt, n, p, h, v;
        exp_t e;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        h = ht - 1;
        v = vt - 1;
        e.pe = 1'b0;
        e.fs = 1'b0;
        if (run) begin
            e.pe = ((tt % cd) == cd - 1);
            n = tt / cd;
            if (n >= 1) begin
                p = n - 1;
                h = p % ht;
                v = (p / ht) % vt;
                e.fs = ((p % (ht * vt)) == 0) && ((tt % cd) == 0);
            end
        end
        e.h   = 10'(h);
        e.v   = 10'(v);
        e.hs  = !(h >= ha + hf && h < ha + hf + hs);
        e.vs  = !(v >= va + vf && v < va + vf + vs);
        e.von = (h < ha) && (v < va);
        return e;
    endfunction

    task automatic compare_all();
        exp_t ef, es;
        ef = ref_model(running, t, 2, H_ACTIVE, H_FP, H_SYNC, H_BP,
                       V_ACTIVE, V_FP, V_SYNC, V_BP);
        es = ref_model(running, t, S_CD, S_HA, S_HF, S_HS, S_HB,
                       S_VA, S_VF, S_VS, S_VB);
        check_val("full.H",   32'(bus_f.H_Count_Value), 32'(ef.h));
        check_val("full.V",   32'(bus_f.V_Count_Value), 32'(ef.v));
        check_val("full.hs",  32'(bus_f.hsync),         32'(ef.hs));
        check_val("full.vs",  32'(bus_f.vsync),         32'(ef.vs));
        check_val("full.von", 32'(bus_f.video_on),      32'(ef.von));
        check_val("full.pe",  32'(bus_f.pix_en),        32'(ef.pe));
        check_val("full.fs",  32'(bus_f.frame_start),   32'(ef.fs));
        check_val("small.H",   32'(bus_s.H_Count_Value), 32'(es.h));
        check_val("small.V",   32'(bus_s.V_Count_Value), 32'(es.v));
        check_val("small.hs",  32'(bus_s.hsync),         32'(es.hs));
        check_val("small.vs",  32'(bus_s.vsync),         32'(es.vs));
        check_val("small.von", 32'(bus_s.video_on),      32'(es.von));
        check_val("small.pe",  32'(bus_s.pix_en),        32'(es.pe));
        check_val("small.fs",  32'(bus_s.frame_start),   32'(es.fs));
    endtask

    // Inputs applied after a falling edge, model stepped at the rising edge,
    // outputs compared 1 time unit later.
    task automatic cycle(input logic r, input logic d);
        rst  = r;
        done = d;
        @(posedge clk);
        if (r) begin
            running = 1'b0;
        end else if (!running && d) begin
            running = 1'b1;
            t = 0;
        end else if (running) begin
            t++;
        end
        #1 compare_all();
        @(negedge clk);
    endtask

    task automatic run_for(input int len);
        for (int i = 0; i < len; i++) begin
            cycle(1'b0, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        int rlen, ilen, len;
        @(negedge clk);

        repeat (3) cycle(1'b1, 1'($urandom_range(0, 1)));
        repeat (1000) cycle(1'b0, 1'b0);
        $display("txn idle: 1000 clk parked, H=%0d V=%0d", bus_f.H_Count_Value, bus_f.V_Count_Value);

        // Longer than two full-size lines and many small frames; Done640 wobbles.
        run_for(4000);
        $display("txn run: 4000 clk, H=%0d V=%0d", bus_f.H_Count_Value, bus_f.V_Count_Value);

        // Done640 held high through reset: restart on the first clock after release.
        repeat (2) cycle(1'b1, 1'b1);
        run_for(700);
        $display("txn reset-with-done: restart, H=%0d V=%0d", bus_f.H_Count_Value, bus_f.V_Count_Value);

        for (int k = 0; k < 10; k++) begin
            rlen = $urandom_range(1, 4);
            ilen = $urandom_range(0, 30);
            len  = $urandom_range(200, 5000);
            repeat (rlen) cycle(1'b1, 1'($urandom_range(0, 1)));
            repeat (ilen) cycle(1'b0, 1'b0);
            run_for(len);
            $display("txn random %0d: rst=%0d idle=%0d run=%0d, H=%0d V=%0d",
                     k, rlen, ilen, len, bus_f.H_Count_Value, bus_f.V_Count_Value);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
